// File: rtl/display_pkg.sv
// rtl/display_pkg.sv - shared Code-B constants, state enum and digit formatting helpers
package display_pkg;

  localparam logic [3:0]  CODEB_DASH  = 4'hA;
  localparam logic [3:0]  CODEB_BLANK = 4'hF;
  localparam logic [31:0] BCD_MAX_DEC = 32'd99_999_999;
  localparam logic [31:0] BCD_MAX_NEG = 32'd9_999_999;
  localparam logic [31:0] BCD_ALL_DASH = {8{CODEB_DASH}};

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_CONVERT,
    ST_BLANK,
    ST_DONE
  } bin2bcd_state_t;

  // Replace leading zero digits with blanks; the units digit always stays visible.
  function automatic logic [31:0] blank_leading(input logic [31:0] bcd);
    logic [31:0] res;
    logic        lead;
    res  = bcd;
    lead = 1'b1;
    for (int i = 7; i >= 1; i--) begin
      if (lead && (bcd[i*4 +: 4] == 4'h0)) begin
        res[i*4 +: 4] = CODEB_BLANK;
      end else begin
        lead = 1'b0;
      end
    end
    return res;
  endfunction

  // Position of the most significant non-zero digit, 0 when the value is below 10.
  function automatic logic [2:0] msd_index(input logic [31:0] bcd);
    logic [2:0] idx;
    idx = 3'd0;
    for (int i = 1; i <= 7; i++) begin
      if (bcd[i*4 +: 4] != 4'h0) begin
        idx = 3'(i);
      end
    end
    return idx;
  endfunction

endpackage

// File: rtl/dabble_adjust.sv
// rtl/dabble_adjust.sv - double-dabble add-3 correction across eight BCD nibbles
module dabble_adjust (
  input  logic [31:0] bcd_in,
  output logic [31:0] bcd_out
);

  for (genvar n = 0; n < 8; n++) begin : g_nib
    assign bcd_out[n*4 +: 4] = (bcd_in[n*4 +: 4] >= 4'd5) ? (bcd_in[n*4 +: 4] + 4'd3)
                                                           : bcd_in[n*4 +: 4];
  end

endmodule

// File: rtl/bin2bcd_fmt.sv
// rtl/bin2bcd_fmt.sv - sequential binary to Code-B converter with blanking and overflow dashes
// Optional two's-complement input with minus sign: define BIN2BCD_FMT_SIGNED_EN.
module bin2bcd_fmt
  import display_pkg::*;
#(
  parameter int WIDTH = 27
) (
  input  logic             clock,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_bin,
  input  logic             blank_en,
  output logic             busy,
  output logic [31:0]      out_num,
  output logic             out_latch
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  bin2bcd_state_t   state_q, state_d;
  logic [WIDTH-1:0] sh_q, sh_d;
  logic [31:0]      acc_q, acc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             flag_q, flag_d;
  logic [31:0]      out_num_q, out_num_d;
  logic             out_latch_q, out_latch_d;

  logic [31:0]      acc_adj;
  logic [WIDTH-1:0] cap_mag;
  logic             cap_ovf;
  logic [31:0]      fmt_word;

  assign in_ready  = (state_q == ST_IDLE) && !rst;
  assign busy      = (state_q != ST_IDLE);
  assign out_num   = out_num_q;
  assign out_latch = out_latch_q;

  dabble_adjust u_adjust (
    .bcd_in  (acc_q),
    .bcd_out (acc_adj)
  );

`ifdef BIN2BCD_FMT_SIGNED_EN
  logic neg_q, neg_d;
  logic cap_neg;

  // The most negative input wraps to itself, which is exactly its unsigned magnitude.
  always_comb begin
    cap_neg = in_bin[WIDTH-1];
    cap_mag = cap_neg ? (~in_bin + 1'b1) : in_bin;
    cap_ovf = cap_neg ? (32'(cap_mag) > BCD_MAX_NEG) : (32'(cap_mag) > BCD_MAX_DEC);
  end

  always_comb begin
    fmt_word = flag_q ? blank_leading(acc_q) : acc_q;
    if (neg_q) begin
      if (flag_q) begin
        for (int i = 0; i < 7; i++) begin
          if (msd_index(acc_q) == 3'(i)) begin
            fmt_word[(i+1)*4 +: 4] = CODEB_DASH;
          end
        end
      end else begin
        fmt_word[31:28] = CODEB_DASH;
      end
    end
  end
`else
  always_comb begin
    cap_mag = in_bin;
    cap_ovf = (32'(in_bin) > BCD_MAX_DEC);
  end

  always_comb begin
    fmt_word = flag_q ? blank_leading(acc_q) : acc_q;
  end
`endif

  always_comb begin
    state_d     = state_q;
    sh_d        = sh_q;
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    flag_d      = flag_q;
    out_num_d   = out_num_q;
    out_latch_d = 1'b0;
`ifdef BIN2BCD_FMT_SIGNED_EN
    neg_d       = neg_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (in_valid && in_ready) begin
          if (cap_ovf) begin
            out_num_d   = BCD_ALL_DASH;
            out_latch_d = 1'b1;
            state_d     = ST_DONE;
          end else begin
            sh_d    = cap_mag;
            acc_d   = 32'h0;
            cnt_d   = CNT_W'(WIDTH);
            flag_d  = blank_en;
`ifdef BIN2BCD_FMT_SIGNED_EN
            neg_d   = cap_neg;
`endif
            state_d = ST_CONVERT;
          end
        end
      end
      ST_CONVERT: begin
        {acc_d, sh_d} = {acc_adj, sh_q} << 1;
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == CNT_W'(1)) begin
          state_d = ST_BLANK;
        end
      end
      ST_BLANK: begin
        out_num_d   = fmt_word;
        out_latch_d = 1'b1;
        state_d     = ST_DONE;
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      sh_q        <= '0;
      acc_q       <= 32'h0;
      cnt_q       <= '0;
      flag_q      <= 1'b0;
      out_num_q   <= 32'h0;
      out_latch_q <= 1'b0;
`ifdef BIN2BCD_FMT_SIGNED_EN
      neg_q       <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      sh_q        <= sh_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      flag_q      <= flag_d;
      out_num_q   <= out_num_d;
      out_latch_q <= out_latch_d;
`ifdef BIN2BCD_FMT_SIGNED_EN
      neg_q       <= neg_d;
`endif
    end
  end

endmodule

// File: tb/tb_bin2bcd_fmt.sv
// tb/tb_bin2bcd_fmt.sv - randomized self-checking bench for bin2bcd_fmt against a decimal model
module tb_bin2bcd_fmt;

  localparam int WIDTH = 27;

  logic             clock = 1'b0;
  logic             rst = 1'b1;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [WIDTH-1:0] in_bin = '0;
  logic             blank_en = 1'b0;
  logic             busy;
  logic [31:0]      out_num;
  logic             out_latch;

  int total = 0;
  int bad = 0;

  bin2bcd_fmt #(.WIDTH(WIDTH)) dut (
    .clock     (clock),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_bin    (in_bin),
    .blank_en  (blank_en),
    .busy      (busy),
    .out_num   (out_num),
    .out_latch (out_latch)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Decimal digits by division; signed build interprets the word as two's complement.
  function automatic logic [31:0] model(input longint unsigned v, input bit b);
    longint unsigned mag;
    longint unsigned t;
    bit              neg;
    int              nd;
    logic [31:0]     r;
    mag = v;
    neg = 1'b0;
`ifdef BIN2BCD_FMT_SIGNED_EN
    if (v >= (64'd1 << (WIDTH - 1))) begin
      neg = 1'b1;
      mag = (64'd1 << WIDTH) - v;
    end
    if (neg && mag > 64'd9_999_999) return 32'hAAAA_AAAA;
`endif
    if (mag > 64'd99_999_999) return 32'hAAAA_AAAA;
    nd = 1;
    t = mag / 10;
    while (t != 0) begin
      nd++;
      t = t / 10;
    end
    r = '0;
    t = mag;
    for (int i = 0; i < 8; i++) begin
      r[i*4 +: 4] = (b && i >= nd) ? 4'hF : 4'(t % 10);
      t = t / 10;
    end
    if (neg) begin
      if (b) r[nd*4 +: 4] = 4'hA;
      else   r[31:28] = 4'hA;
    end
    return r;
  endfunction

  task automatic wait_ready();
    int n;
    n = 0;
    while (!in_ready && n < 100) begin
      @(negedge clock);
      n++;
    end
    if (!in_ready) check("ready_timeout", 64'(in_ready), 64'd1);
  endtask

  task automatic run_one(input logic [WIDTH-1:0] v, input bit b, input bit pulse);
    int          c;
    int          lat_c;
    int          early_rdy;
    logic [31:0] exp;
    logic [31:0] got;
    bit          ovf;
    exp = model(64'(v), b);
    ovf = (exp == 32'hAAAA_AAAA);
    wait_ready();
    in_bin   = v;
    blank_en = b;
    in_valid = 1'b1;
    @(posedge clock);
    @(negedge clock);
    in_valid  = 1'b0;
    c         = 1;
    lat_c     = 0;
    early_rdy = 0;
    got       = '0;
    while (lat_c == 0 && c <= 80) begin
      if (out_latch) begin
        lat_c = c;
        got   = out_num;
      end else begin
        if (in_ready) early_rdy++;
        in_valid = (pulse && c == 5);
        if (pulse && c == 5) in_bin = 7;
        @(negedge clock);
        c++;
      end
    end
    check($sformatf("latency_%0d", v), 64'(lat_c), ovf ? 64'd1 : 64'(WIDTH + 2));
    check($sformatf("out_num_%0d_b%0d", v, b), 64'(got), 64'(exp));
    check("ready_low_while_busy", 64'(early_rdy), 64'd0);
    check("busy_in_done", 64'(busy), 64'd1);
    check("ready_in_done", 64'(in_ready), 64'd0);
    @(negedge clock);
    check("latch_one_cycle", 64'(out_latch), 64'd0);
    check("ready_after_done", 64'(in_ready), 64'd1);
    check("out_num_hold", 64'(out_num), 64'(exp));
  endtask

  task automatic run_reset_abort();
    int          c;
    int          seen;
    wait_ready();
    in_bin   = 27'd55_555;
    blank_en = 1'b1;
    in_valid = 1'b1;
    @(posedge clock);
    @(negedge clock);
    in_valid = 1'b0;
    for (c = 1; c < 10; c++) @(negedge clock);
    rst = 1'b1;
    #1;
    check("ready_in_rst", 64'(in_ready), 64'd0);
    @(negedge clock);
    rst = 1'b0;
    #1;
    check("abort_out_num", 64'(out_num), 64'd0);
    check("abort_latch", 64'(out_latch), 64'd0);
    check("abort_busy", 64'(busy), 64'd0);
    check("abort_ready", 64'(in_ready), 64'd1);
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clock);
      if (out_latch) seen++;
    end
    check("abort_no_latch", 64'(seen), 64'd0);
  endtask

  initial begin
    logic [WIDTH-1:0] v;
    repeat (3) @(negedge clock);
    check("rst_ready", 64'(in_ready), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_latch", 64'(out_latch), 64'd0);
    check("rst_out_num", 64'(out_num), 64'd0);
    rst = 1'b0;
    #1;
    check("ready_after_rst", 64'(in_ready), 64'd1);

    run_one(27'd12_345_678, 1'b1, 1'b0);
    run_one(27'd0, 1'b1, 1'b0);
    run_one(27'd0, 1'b0, 1'b0);
    run_one(27'd42, 1'b1, 1'b1);
    run_one(27'd100_000_000, 1'b1, 1'b0);
    run_one(27'd99_999_999, 1'b1, 1'b0);
    run_one(27'd99_999_999, 1'b0, 1'b0);
    run_one(27'd987, 1'b0, 1'b0);
    v = 27'd42;
    v = ~v + 1'b1;
    run_one(v, 1'b1, 1'b0);
    run_one(v, 1'b0, 1'b0);
    v = '0;
    v[WIDTH-1] = 1'b1;
    run_one(v, 1'b1, 1'b0);
    run_reset_abort();

    for (int i = 0; i < 30; i++) begin
      case (i % 3)
        0: v = WIDTH'($urandom_range(0, 999));
        1: v = WIDTH'($urandom_range(99_999_990, 100_000_010));
        default: v = WIDTH'($urandom);
      endcase
      run_one(v, 1'($urandom_range(0, 1)), 1'b0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout got=%0d exp=%0d", total, -1);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/bin2bcd_fmt.md
# bin2bcd_fmt

Upstream feeder for the MAX7219 display driver: converts a binary value into eight packed Code-B digit nibbles ready for the driver's `num` input. It applies leading-zero blanking and overflow marking, and pulses a one-cycle latch strobe when a new word is valid. The conversion is a sequential double-dabble: one bit per cycle, add-3 correction per nibble.

## Interface
- `WIDTH`, default 27: binary input width, legal range 4..27.
- `clock`  in  1  system clock; all state changes on the rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `in_valid`  in  1  `in_bin` and `blank_en` are valid.
- `in_ready`  out  1  high only in IDLE with `rst` low; a transfer occurs when `in_valid && in_ready` at an edge.
- `in_bin`  in  WIDTH  value to convert.
- `blank_en`  in  1  enable leading-zero blanking; captured with `in_bin`.
- `busy`  out  1  high when state is not IDLE.
- `out_num`  out  32  eight Code-B nibbles; `[31:28]` is the MSD.
- `out_latch`  out  1  one-cycle strobe; `out_num` is valid in the same cycle.

## Operation
- States: IDLE, CONVERT, BLANK, DONE.
- IDLE, on transfer:
  - Capture `in_bin` into the shift register and `blank_en` into a flag.
  - Clear the 32-bit BCD accumulator.
  - Load bit counter = WIDTH.
  - Go to CONVERT.
- IDLE, overflow at capture (value > 99_999_999; only possible when WIDTH = 27):
  - Go directly to DONE with `out_num` = 32'hAAAA_AAAA (all dashes).
- CONVERT, each cycle:
  - Every nibble ≥ 5 gets +3.
  - Then shift {accumulator, shift register} left by one.
  - Decrement the counter.
  - When the counter reaches 1, go to BLANK on the next edge. CONVERT lasts exactly WIDTH cycles.
- BLANK, one cycle:
  - If the flag is set, scan from nibble 7 down to nibble 1 and replace each leading 0 with 4'hF.
  - Nibble 0 is never blanked.
  - Register the result into `out_num`, set `out_latch`, go to DONE.
- DONE, one cycle:
  - `out_latch` = 1, `in_ready` = 0.
  - Next edge: clear `out_latch`, go to IDLE.
- `out_num` holds its value until the next DONE.
- `in_valid` while busy is ignored; no queuing.
- Reset values:
  - `out_num` = 32'h0000_0000.
  - `out_latch` = 0, `busy` = 0.
  - `in_ready` = 0 while `rst` is high.
  - State = IDLE.
- `rst` asserted mid-conversion: the next edge aborts to IDLE, no `out_latch` is produced, and `out_num` is cleared.

## Timing
- Transfer at edge k. CONVERT occupies cycles k+1..k+WIDTH. BLANK is cycle k+WIDTH+1. DONE is cycle k+WIDTH+2, with `out_latch` high.
- Normal latency: WIDTH+2 cycles. For WIDTH = 27, that is 29.
- Overflow latency: 1 cycle (DONE in cycle k+1).
- `in_ready` rises in cycle k+WIDTH+3. The minimum transfer-to-transfer period is WIDTH+3 cycles.
- `in_valid` held high continuously is accepted again at the first IDLE edge.

## Configuration
- `BIN2BCD_FMT_SIGNED_EN` defined:
  - `in_bin` is two's complement; the magnitude is converted.
  - Negative values with magnitude > 9_999_999 produce overflow (AAAA_AAAA).
  - A negative result places 4'hA (minus) in the nibble directly left of the most significant non-blanked digit. If `blank_en` = 0, the minus goes in nibble 7 and must not overwrite a significant digit (magnitude ≤ 9_999_999 guarantees this).
  - The most negative input converts by its unsigned magnitude.
- `BIN2BCD_FMT_SIGNED_EN` undefined: `in_bin` is unsigned and no sign logic is synthesized.

## Structure
- Shared package `display_pkg`:
  - `CODEB_DASH` = 4'hA, `CODEB_BLANK` = 4'hF.
  - `BCD_MAX_DEC` = 99_999_999, `BCD_MAX_NEG` = 9_999_999.
  - State enum `bin2bcd_state_t`.
- Sub-module `dabble_adjust`: combinational 32-bit add-3-if-≥5 across eight nibbles. It is instantiated once in CONVERT.

## Test plan
- WIDTH = 27, `in_bin` = 12_345_678, `blank_en` = 1 → `out_num` = 32'h1234_5678; `out_latch` high for exactly one cycle, 29 cycles after the transfer.
- `in_bin` = 0: with `blank_en` = 1 → 32'hFFFF_FFF0; with `blank_en` = 0 → 32'h0000_0000.
- `in_bin` = 42, `blank_en` = 1 → 32'hFFFF_FF42. A second `in_valid` pulsed during CONVERT is ignored, and `in_ready` stays low until cycle 30.
- `in_bin` = 100_000_000 → 32'hAAAA_AAAA, with `out_latch` in the cycle after the transfer.
- `rst` pulsed in the 10th CONVERT cycle → no `out_latch`, `out_num` = 0, `in_ready` = 1 in the cycle after `rst` falls.
- `in_bin` = −42 (27-bit), `blank_en` = 1:
  - With `BIN2BCD_FMT_SIGNED_EN` → 32'hFFFF_FA42.
  - Without it → 32'hAAAA_AAAA (value 134_217_686 overflows).
